// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that pushes one 4-bit nibble per clock through
// a single ripple-carry slice, least-significant nibble first.

module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16   // multiple of 4, at least 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [3:0]       slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] sum_next;

    adder4 u_slice (
        .a  (a_sh_q[3:0]),
        .b  (b_sh_q[3:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // New nibble enters at the top; after NIB steps the register holds the full sum.
    assign sum_next = WIDTH'({slice_s, sum_sh_q} >> 4);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready depends only on state (and rst); out_valid is a flop
    // that stays high with S/cout/ovf stable until out_ready is seen.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    sum_sh_d = '0;
                    carry_d  = cin;
                    cnt_d    = '0;
                    a_msb_d  = A[WIDTH-1];
                    b_msb_d  = B[WIDTH-1];
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 4;
                b_sh_d   = b_sh_q >> 4;
                sum_sh_d = sum_next;
                carry_d  = slice_co;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    s_d         = sum_next;
                    cout_d      = slice_co;
                    ovf_d       = (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            s_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a 16-bit and a 4-bit instance, each with a
// scoreboard fed at acceptance and drained by a monitor on output handshakes.

module tb_nibble_serial_adder;
    localparam int W    = 16;
    localparam int NIB  = W / 4;
    localparam int NIB4 = 1;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
    logic [W-1:0] a, b, s;
    logic         in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4, busy4;
    logic [3:0]   a4, b4, s4;

    logic [17:0] exp_q[$];
    int          acc_q[$];
    logic [5:0]  exp4_q[$];
    int          acc4_q[$];
    logic        prev_v  = 1'b0;
    logic        prev_v4 = 1'b0;
    bit          rand_done;

    nibble_serial_adder #(.WIDTH(W)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .S(s), .cout(cout), .ovf(ovf), .busy(busy)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(a4), .B(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .S(s4), .cout(cout4), .ovf(ovf4), .busy(busy4)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Plain integer arithmetic: returns {cout, ovf, S (zero-padded to 16)}.
    function automatic logic [17:0] ref_add(input int wd, input logic [15:0] x,
                                            input logic [15:0] y, input logic c);
        longint half, full, sx, sy, ss, u;
        logic [17:0] r;
        half = longint'(1) << (wd - 1);
        full = longint'(1) << wd;
        u    = longint'(x) + longint'(y) + longint'(c);
        sx   = (longint'(x) >= half) ? longint'(x) - full : longint'(x);
        sy   = (longint'(y) >= half) ? longint'(y) - full : longint'(y);
        ss   = sx + sy + longint'(c);
        r         = '0;
        r[15:0]   = 16'(u % full);
        r[17]     = (u >= full);
        r[16]     = (ss >= half) || (ss < -half);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic c,
                          output int t);
        bit ok;
        a = x; b = y; cin = c; in_valid = 1'b1;
        ok = 0; t = -1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                t  = cyc + 1;
                exp_q.push_back(ref_add(16, x, y, c));
                acc_q.push_back(t);
            end
        end
        step();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        if (!ok) chk("send16_accept_timeout", 1, 0);
    endtask

    task automatic send4(input logic [3:0] x, input logic [3:0] y, input logic c);
        bit ok;
        logic [17:0] r;
        a4 = x; b4 = y; cin4 = c; in_valid4 = 1'b1;
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (in_ready4) begin
                ok = 1;
                r  = ref_add(4, {12'h0, x}, {12'h0, y}, c);
                exp4_q.push_back({r[17], r[16], r[3:0]});
                acc4_q.push_back(cyc + 1);
            end
        end
        step();
        in_valid4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
        if (!ok) chk("send4_accept_timeout", 1, 0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || exp4_q.size() != 0) && k < 400) begin
            step();
            k++;
        end
        if (k >= 400) chk("drain_timeout", 1, 0);
        step();
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [17:0] e;
        int          t;
        if (!rst) begin
            if (out_valid && !prev_v) begin
                if (acc_q.size() == 0) chk("lat16_unexpected_valid", 1, 0);
                else begin
                    t = acc_q.pop_front();
                    chk("lat16", cyc - t, NIB);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("res16_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("s16", s, e[15:0]);
                    chk("cout16", cout, e[17]);
                    chk("ovf16", ovf, e[16]);
                end
            end
        end
        prev_v = out_valid;
    end

    always @(negedge clk) begin
        logic [5:0] e;
        int         t;
        if (!rst) begin
            if (out_valid4 && !prev_v4) begin
                if (acc4_q.size() == 0) chk("lat4_unexpected_valid", 1, 0);
                else begin
                    t = acc4_q.pop_front();
                    chk("lat4", cyc - t, NIB4);
                end
            end
            if (out_valid4 && out_ready4) begin
                if (exp4_q.size() == 0) chk("res4_unexpected", 1, 0);
                else begin
                    e = exp4_q.pop_front();
                    chk("s4", s4, e[3:0]);
                    chk("cout4", cout4, e[5]);
                    chk("ovf4", ovf4, e[4]);
                end
            end
        end
        prev_v4 = out_valid4;
    end

    // ---------------- test sequence ----------------
    initial begin
        int t1, t2, t, nv, k;
        logic [17:0] r;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b0;
        rand_done = 0;
        step(); step(); step();

        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cout_ovf", {cout, ovf}, 0);
        step();
        rst = 1'b0; out_ready = 1'b1; out_ready4 = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_in_ready4", in_ready4, 1);
        step();

        // back-to-back issue with in_valid held: interval is NIB+2
        send16(16'h1234, 16'h0FFF, 1'b0, t1);
        send16(16'hFFFF, 16'h0001, 1'b0, t2);
        chk("issue_interval", t2 - t1, NIB + 2);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("out_valid_pulse_width", nv, 1);
        step();

        send16(16'h0000, 16'h0000, 1'b1, t);
        send16(16'h7FFF, 16'h0001, 1'b0, t);
        send16(16'h8000, 16'h8000, 1'b0, t);
        drain();

        // backpressure: result held while out_ready is low, inputs ignored
        out_ready = 1'b0;
        send16(16'h1111, 16'h2222, 1'b1, t);
        r = ref_add(16, 16'h1111, 16'h2222, 1'b1);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_s", s, r[15:0]);
            chk("bp_cout_ovf", {cout, ovf}, {r[17], r[16]});
            chk("bp_in_ready", in_ready, 0);
        end
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        step();

        // reset during the second RUN cycle abandons the transaction
        send16(16'h5555, 16'hAAAA, 1'b1, t);
        step();
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("rst_mid_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_s", s, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_in_ready_after", in_ready, 1);
        for (int i = 0; i < 8; i++) step();
        send16(16'h00FF, 16'h0001, 1'b0, t);
        drain();

        // randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send16(W'($urandom), W'($urandom), 1'($urandom), t);
                    for (int g = $urandom_range(0, 3); g > 0; g--) step();
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    step();
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // 4-bit instance: one RUN cycle
        send4(4'h9, 4'h8, 1'b1);
        send4(4'hF, 4'h1, 1'b0);
        send4(4'h7, 4'h0, 1'b1);
        for (int i = 0; i < 20; i++) send4(4'($urandom), 4'($urandom), 1'($urandom));
        drain();

        chk("final_queue16_empty", exp_q.size(), 0);
        chk("final_queue4_empty", exp4_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
